// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-buffered UART core.
package uart_pkg;

  localparam int unsigned OVERSAMPLE    = 16;
  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // Parity bit for a zero-extended payload (extra zeros do not change the XOR).
  function automatic logic par_bit(input logic [MAX_DATA_BITS-1:0] d, input parity_e mode);
    return (mode == PAR_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered first-word-fall-through head, level and flags.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic             push_ok;
  logic             pop_ok;
  logic [LVL_W-1:0] level_nxt;

  // Push is ignored when full, pop is ignored when empty.
  assign push_ok    = push & ~full;
  assign pop_ok     = pop & ~empty;
  assign rd_ptr_nxt = rd_ptr + AW'(1);
  assign level_nxt  = level + LVL_W'(push_ok) - LVL_W'(pop_ok);

  // Storage array; contents need no reset, validity is tracked by level.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy, flags and the registered head word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      rd_data <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr_nxt;
      level <= level_nxt;
      full  <= (level_nxt == LVL_W'(DEPTH));
      empty <= (level_nxt == '0);
      if (pop_ok && level == LVL_W'(1)) begin
        if (push_ok) rd_data <= wr_data;
      end else if (pop_ok) begin
        rd_data <= mem[rd_ptr_nxt];
      end else if (empty && push_ok) begin
        rd_data <= wr_data;
      end
    end
  end

endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with TX/RX FIFOs, x16 baud generator and selectable parity.
// Build option: UART_LOOPBACK_EN routes the TX shifter into the receiver and
// holds the TxD pin high; without it RX listens to RxD and TxD carries the shifter.
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          n_RST,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  input  logic                          clr_err,
  output logic                          PE_Fg,
  output logic                          FE_Fg,
  output logic                          OE_Fg,
  output logic                          tx_busy,
  input  logic                          RxD,
  output logic                          TxD
);

  localparam int unsigned DIV        = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TCNT_W     = 5;
  localparam int unsigned BIT_W      = 4;
  localparam int unsigned STOP_TICKS = OVERSAMPLE * STOP_BITS;
  localparam parity_e     PAR_MODE   = parity_e'(2'(PARITY));
  localparam bit          PAR_EN     = (PAR_MODE != PAR_NONE);

  // ---------------------------------------------------------------- baud tick
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  // Free-running divider; tick is a one-clock pulse at each wrap.
  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_W'(DIV - 1)) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      tick    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- TX path
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_full;
  logic                 tx_empty;
  logic                 tx_pop_c;
  tx_state_e            tx_state;
  logic [TCNT_W-1:0]    tx_cnt;
  logic [BIT_W-1:0]     tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_line;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (n_RST),
    .push    (tx_valid),
    .wr_data (tx_data),
    .pop     (tx_pop_c),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .level   (tx_level)
  );

  assign tx_ready = ~tx_full;

  // Shifter takes a byte from IDLE, or straight from the end of STOP for back-to-back frames.
  assign tx_pop_c = tick && !tx_empty &&
                    ((tx_state == TX_IDLE) ||
                     ((tx_state == TX_STOP) && (tx_cnt == TCNT_W'(STOP_TICKS - 1))));

  // TX frame sequencer; every state lasts 16 ticks, STOP lasts 16 per stop bit.
  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
      tx_busy  <= 1'b0;
    end else if (tick) begin
      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty) begin
            tx_shift <= tx_head;
            tx_par   <= par_bit(MAX_DATA_BITS'(tx_head), PAR_MODE);
            tx_line  <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= TX_START;
            tx_busy  <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_cnt == TCNT_W'(OVERSAMPLE - 1)) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_line  <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + TCNT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt == TCNT_W'(OVERSAMPLE - 1)) begin
            tx_cnt <= '0;
            if (tx_idx == BIT_W'(DATA_BITS - 1)) begin
              if (PAR_EN) begin
                tx_line  <= tx_par;
                tx_state <= TX_PARITY;
              end else begin
                tx_line  <= 1'b1;
                tx_state <= TX_STOP;
              end
            end else begin
              tx_idx   <= tx_idx + BIT_W'(1);
              tx_shift <= tx_shift >> 1;
              tx_line  <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + TCNT_W'(1);
          end
        end
        TX_PARITY: begin
          if (tx_cnt == TCNT_W'(OVERSAMPLE - 1)) begin
            tx_cnt   <= '0;
            tx_line  <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + TCNT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt == TCNT_W'(STOP_TICKS - 1)) begin
            tx_cnt <= '0;
            if (!tx_empty) begin
              tx_shift <= tx_head;
              tx_par   <= par_bit(MAX_DATA_BITS'(tx_head), PAR_MODE);
              tx_line  <= 1'b0;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
              tx_busy  <= 1'b0;
            end
          end else begin
            tx_cnt <= tx_cnt + TCNT_W'(1);
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          tx_line  <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- pin mux
  logic rx_in;

`ifdef UART_LOOPBACK_EN
  assign TxD   = 1'b1;
  assign rx_in = tx_line;
`else
  assign TxD   = tx_line;
  assign rx_in = RxD;
`endif

  // ---------------------------------------------------------------- RX path
  logic                 rx_s1;
  logic                 rx_s2;
  logic                 rx_prev;
  rx_state_e            rx_state;
  logic [3:0]           rx_cnt;
  logic [BIT_W-1:0]     rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 frame_pe;
  logic                 frame_fe;
  logic                 rx_push;
  logic                 rx_full;
  logic                 rx_empty;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX frame sequencer: start validated at tick 8, then one sample per bit centre.
  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      frame_pe <= 1'b0;
      frame_fe <= 1'b0;
      rx_push  <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_cnt == 4'(OVERSAMPLE / 2 - 1)) begin
              rx_cnt   <= '0;
              rx_idx   <= '0;
              frame_pe <= 1'b0;
              rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
            end else begin
              rx_cnt <= rx_cnt + 4'(1);
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (rx_cnt == 4'(OVERSAMPLE - 1)) begin
              rx_cnt   <= '0;
              rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
              if (rx_idx == BIT_W'(DATA_BITS - 1)) begin
                rx_state <= PAR_EN ? RX_PARITY : RX_STOP;
              end else begin
                rx_idx <= rx_idx + BIT_W'(1);
              end
            end else begin
              rx_cnt <= rx_cnt + 4'(1);
            end
          end
        end
        RX_PARITY: begin
          if (tick) begin
            if (rx_cnt == 4'(OVERSAMPLE - 1)) begin
              rx_cnt   <= '0;
              frame_pe <= (rx_s2 != par_bit(MAX_DATA_BITS'(rx_shift), PAR_MODE));
              rx_state <= RX_STOP;
            end else begin
              rx_cnt <= rx_cnt + 4'(1);
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (rx_cnt == 4'(OVERSAMPLE - 1)) begin
              rx_cnt   <= '0;
              frame_fe <= ~rx_s2;
              rx_push  <= 1'b1;
              rx_state <= rx_s2 ? RX_IDLE : RX_BREAK;
            end else begin
              rx_cnt <= rx_cnt + 4'(1);
            end
          end
        end
        RX_BREAK: begin
          if (rx_s2) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (n_RST),
    .push    (rx_push),
    .wr_data (rx_shift),
    .pop     (rx_ready),
    .rd_data (rx_data),
    .full    (rx_full),
    .empty   (rx_empty),
    .level   (rx_level)
  );

  assign rx_valid = ~rx_empty;

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      PE_Fg <= 1'b0;
      FE_Fg <= 1'b0;
      OE_Fg <= 1'b0;
    end else begin
      PE_Fg <= (rx_push & frame_pe) | (PE_Fg & ~clr_err);
      FE_Fg <= (rx_push & frame_fe) | (FE_Fg & ~clr_err);
      OE_Fg <= (rx_push & rx_full)  | (OE_Fg & ~clr_err);
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core at DIV=2 (one bit = 32 clocks).
module tb_uart_fifo_core;

  localparam int unsigned BIT_CLK = 32;

  logic       clk = 1'b0;
  logic       n_RST;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       rx_ready;
  logic       clr_err;
  logic       rxd_drv;
  int         main_sel;   // 0: TxD looped back, 1: rxd_drv, other: idle high
  logic       par_sel;
  logic       main_rxd;
  logic       par_rxd;

  logic       tx_ready, rx_valid, PE_Fg, FE_Fg, OE_Fg, tx_busy, TxD;
  logic [7:0] rx_data;
  logic [4:0] tx_level, rx_level;

  logic       e_tx_ready, e_rx_valid, e_pe, e_fe, e_oe, e_busy, e_txd;
  logic [7:0] e_rx_data;
  logic [4:0] e_tx_level, e_rx_level;
  logic       o_tx_ready, o_rx_valid, o_pe, o_fe, o_oe, o_busy, o_txd;
  logic [7:0] o_rx_data;
  logic [4:0] o_tx_level, o_rx_level;

  int n_cmp = 0;
  int n_err = 0;
  int busy_cyc = 0;

  always #5 clk = ~clk;

  always_comb begin
    main_rxd = 1'b1;
    if (main_sel == 0)      main_rxd = TxD;
    else if (main_sel == 1) main_rxd = rxd_drv;
  end
  assign par_rxd = par_sel ? rxd_drv : 1'b1;

  always @(negedge clk) if (tx_busy) busy_cyc <= busy_cyc + 1;

  uart_fifo_core #(.CLK_HZ(50_000_000), .BAUD(1_562_500), .PARITY(0)) u_dut (
    .clk(clk), .n_RST(n_RST), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_level(tx_level),
    .rx_level(rx_level), .clr_err(clr_err), .PE_Fg(PE_Fg), .FE_Fg(FE_Fg), .OE_Fg(OE_Fg),
    .tx_busy(tx_busy), .RxD(main_rxd), .TxD(TxD));

  uart_fifo_core #(.CLK_HZ(50_000_000), .BAUD(1_562_500), .PARITY(1)) u_even (
    .clk(clk), .n_RST(n_RST), .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(e_tx_ready),
    .rx_data(e_rx_data), .rx_valid(e_rx_valid), .rx_ready(1'b0), .tx_level(e_tx_level),
    .rx_level(e_rx_level), .clr_err(1'b0), .PE_Fg(e_pe), .FE_Fg(e_fe), .OE_Fg(e_oe),
    .tx_busy(e_busy), .RxD(par_rxd), .TxD(e_txd));

  uart_fifo_core #(.CLK_HZ(50_000_000), .BAUD(1_562_500), .PARITY(2)) u_odd (
    .clk(clk), .n_RST(n_RST), .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(o_tx_ready),
    .rx_data(o_rx_data), .rx_valid(o_rx_valid), .rx_ready(1'b0), .tx_level(o_tx_level),
    .rx_level(o_rx_level), .clr_err(1'b0), .PE_Fg(o_pe), .FE_Fg(o_fe), .OE_Fg(o_oe),
    .tx_busy(o_busy), .RxD(par_rxd), .TxD(o_txd));

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit i = i-th bit on the line (start first)
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  // Push an incrementing sequence until tx_ready drops; returns the accepted count.
  task automatic push_burst(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!tx_ready) break;
      tx_data  = 8'(n);
      tx_valid = 1'b1;
      n++;
    end
    tx_valid = 1'b0;
  endtask

  task automatic capture_frame(output logic [9:0] fr, output logic ok);
    ok = 1'b0;
    fr = '1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (TxD == 1'b0) ok = 1'b1;
    end
    if (ok) begin
      repeat (BIT_CLK / 2) @(negedge clk);
      fr[0] = TxD;
      for (int b = 1; b < 10; b++) begin
        repeat (BIT_CLK) @(negedge clk);
        fr[b] = TxD;
      end
    end
  endtask

  task automatic wait_rx_valid(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (rx_valid) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic wait_tx_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 8000 && !ok; i++) begin
      @(negedge clk);
      if (!tx_busy) ok = 1'b1;
    end
  endtask

  task automatic send_serial(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxd_drv = bits[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  initial begin
    logic [9:0]  fr;
    logic        ok;
    int          n;
    int          b0;
    logic [7:0]  got [$];

    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h3C, 10'b1_00111100_0};
    vecs[4] = '{8'h81, 10'b1_10000001_0};

    n_RST = 1'b0; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; clr_err = 1'b0;
    rxd_drv = 1'b1; main_sel = 0; par_sel = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({TxD, tx_ready, rx_valid, tx_busy, PE_Fg, FE_Fg, OE_Fg}), 32'b1100000);
    check("reset_tx_level", 32'(tx_level), 32'd0);
    check("reset_rx_level", 32'(rx_level), 32'd0);
    n_RST = 1'b1;
    repeat (4) @(negedge clk);

    // Table: single frames through the external loop
    for (int v = 0; v < 5; v++) begin
      push_byte(vecs[v].data);
      capture_frame(fr, ok);
      check($sformatf("tx_start_%0d", v), 32'(ok), 32'd1);
      check($sformatf("tx_frame_%0d", v), 32'(fr), 32'(vecs[v].frame));
      wait_rx_valid(ok);
      check($sformatf("rx_valid_%0d", v), 32'(ok), 32'd1);
      check($sformatf("rx_data_%0d", v), 32'(rx_data), 32'(vecs[v].data));
      check($sformatf("flags_%0d", v), 32'({PE_Fg, FE_Fg, OE_Fg}), 32'd0);
      pop_rx();
      repeat (BIT_CLK) @(negedge clk);
    end

    // Burst: 16 fill the FIFO plus one already taken by the shifter
    repeat (64) @(negedge clk);
    rx_ready = 1'b1;
    b0 = busy_cyc;
    push_burst(n);
    check("burst_accepted", 32'(n), 32'd17);
    check("burst_full_ready", 32'(tx_ready), 32'd0);
    for (int i = 0; i < 7000 && got.size() < 17; i++) begin
      @(negedge clk);
      if (rx_valid) got.push_back(rx_data);
    end
    check("burst_rx_count", 32'(got.size()), 32'd17);
    for (int i = 0; i < got.size(); i++) check($sformatf("burst_order_%0d", i), 32'(got[i]), 32'(i));
    wait_tx_idle(ok);
    check("burst_tx_idle", 32'(ok), 32'd1);
    check("burst_no_gap_cycles", 32'(busy_cyc - b0), 32'd5440);
    rx_ready = 1'b0;
    repeat (64) @(negedge clk);

    // Overrun: 17 frames into a 16-deep RX FIFO that is never popped
    push_burst(n);
    check("ovr_accepted", 32'(n), 32'd17);
    wait_tx_idle(ok);
    check("ovr_tx_idle", 32'(ok), 32'd1);
    repeat (100) @(negedge clk);
    check("ovr_rx_level", 32'(rx_level), 32'd16);
    check("ovr_flags", 32'({PE_Fg, FE_Fg, OE_Fg}), 32'b001);
    check("ovr_head", 32'(rx_data), 32'h00);
    pulse_clr();
    check("ovr_clr", 32'(OE_Fg), 32'd0);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("ovr_drain_%0d", k), 32'({rx_valid, rx_data}), 32'({1'b1, 8'(k)}));
      pop_rx();
    end
    check("ovr_drained_level", 32'(rx_level), 32'd0);

    // Parity: 0x03 with parity bit 1 (even parity expects 0, odd expects 1)
    main_sel = 2; par_sel = 1'b1;
    repeat (8) @(negedge clk);
    send_serial({5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
    repeat (20) @(negedge clk);
    check("even_pe", 32'({e_pe, e_fe}), 32'b10);
    check("even_data", 32'({e_rx_valid, e_rx_data}), 32'h103);
    check("odd_pe", 32'({o_pe, o_fe}), 32'b00);
    check("odd_data", 32'({o_rx_valid, o_rx_data}), 32'h103);
    par_sel = 1'b0;

    // Framing: stop bit forced low
    main_sel = 1;
    repeat (8) @(negedge clk);
    send_serial({6'b0, 1'b0, 8'h55, 1'b0}, 10);
    repeat (40) @(negedge clk);
    check("fe_flags", 32'({PE_Fg, FE_Fg, OE_Fg}), 32'b010);
    check("fe_data", 32'({rx_valid, rx_data}), 32'h155);
    pop_rx();
    pulse_clr();
    check("fe_clr", 32'(FE_Fg), 32'd0);

    // Break: line low for 40 bit-times yields exactly one frame
    rxd_drv = 1'b0;
    repeat (40 * BIT_CLK) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (400) @(negedge clk);
    check("break_level", 32'(rx_level), 32'd1);
    check("break_frame", 32'({FE_Fg, rx_data}), 32'h100);
    pop_rx();
    pulse_clr();

    // Glitch: 4-clock low pulse is rejected at the start-bit check
    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_level", 32'(rx_level), 32'd0);
    check("glitch_flags", 32'({PE_Fg, FE_Fg, OE_Fg}), 32'd0);

    // Reset in the middle of a transmission
    main_sel = 0;
    push_byte(8'h00);
    push_byte(8'h11);
    push_byte(8'h22);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (TxD == 1'b0) ok = 1'b1;
    end
    check("rst_tx_started", 32'(ok), 32'd1);
    repeat (50) @(negedge clk);
    check("rst_pre_txd", 32'(TxD), 32'd0);
    n_RST = 1'b0;
    #1;
    check("rst_async_txd", 32'(TxD), 32'd1);
    check("rst_async_levels", 32'({tx_level, rx_level}), 32'd0);
    check("rst_async_busy", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk);
    n_RST = 1'b1;
    repeat (100) @(negedge clk);
    check("rst_after_txd", 32'({TxD, tx_busy, tx_level}), 32'({1'b1, 1'b0, 5'd0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
